counter_load_sequencer: RTL
===========================

// Module: counter_load_sequencer
// PURPOSE
//  Round-robin sequencer sharing one loadable up-counter (load/c_in/c_out) among NREQ requesters.
//  - Each requester supplies a start and end value. When granted, the block loads start, lets the counter run, and freezes it at end.
//  - It then pulses done for that requester.
//  - Sits between requester logic and the counter; it is the sole driver of the counter load/c_in pins.
// PARAMETERS
//  NREQ   4  number of requesters (2..8)
//  WIDTH  4  counter width in bits; must match the counter instance
// PORTS
//  clk        in   1            clock; all state changes on posedge
//  rst_n      in   1            reset_n - low to reset; synchronous, active-low
//  ena        in   1            0 = freeze FSM and hold counter value
//  req        in   NREQ         level request; held high until done or abort
//  req_start  in   NREQ*WIDTH   packed start values; slice i = [i*WIDTH +: WIDTH]
//  req_end    in   NREQ*WIDTH   packed end values; same slicing
//  gnt        out  NREQ         one-hot grant (registered)
//  done       out  NREQ         one-cycle completion pulse, one-hot (registered)
//  busy       out  1            1 in LOAD or RUN
//  cnt_load   out  1            to counter load pin (combinational)
//  cnt_value  out  WIDTH        to counter c_in (combinational)
//  cnt_q      in   WIDTH        from counter c_out
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - State -> IDLE; gnt, done, busy -> 0; RR pointer -> 0.
//   - While rst_n=0: cnt_load=0, cnt_value=0 (counter resets itself).
//  HOLD (counter freeze):
//   - cnt_load=1, cnt_value=cnt_q, so the counter reloads its own value.
//   - HOLD is driven in IDLE, whenever ena=0, and on the terminal RUN cycle.
//  ena=0: state, gnt, ptr frozen; done forced 0; HOLD driven.
//  FSM states: IDLE, LOAD, RUN.
//  IDLE:
//   - HOLD driven.
//   - If any req: pick first set bit searching ptr, ptr+1, ... mod NREQ.
//   - gnt <= onehot(k), latch start/end of k internally, ptr <= (k+1) mod NREQ, -> LOAD.
//   - Grant decision takes 1 cycle from req sampled high.
//  LOAD: cnt_load=1, cnt_value=latched start; -> RUN.
//  RUN, cnt_load=0 (counter increments) unless terminal:
//   - Terminal when cnt_q == latched end: HOLD, done[k] <= 1, gnt <= 0, -> IDLE.
//  Latency:
//   - Counter sits at start the first RUN cycle.
//   - RUN length = ((end - start) mod 2^WIDTH) + 1 cycles.
//   - done appears the cycle after terminal detect; counter holds end afterwards.
//  Wrap-around: end < start is legal; counter wraps through 2^WIDTH-1 -> 0 (mod 2^WIDTH arithmetic).
//  start == end: terminal on first RUN cycle; done 3 cycles after grant sample.
//  Abort: req[k]=0 during LOAD or RUN:
//   - Next state IDLE, gnt <= 0, no done, HOLD that cycle.
//   - ptr is still advanced past k.
//  Other requesters changing req mid-operation: no effect until IDLE.
//  Start/end inputs are sampled only at grant; later changes are ignored.
//  Requester must drop req the cycle done is seen. If req is still high in IDLE, it is a new request, arbitrated normally.
//  Back-to-back: IDLE lasts exactly 1 cycle between jobs when requests are pending.
//  Invariants:
//   - gnt and done each at most one-hot.
//   - done never coincides with gnt on the same index.
// TESTING
//  1 Reset: rst_n=0 3 cycles with req=4'hF -> gnt=0, done=0, busy=0, cnt_load=0; after release first gnt=4'b0001.
//  2 Single job: req[2], start=3, end=7 -> cnt_q 3,4,5,6,7 in RUN; done=4'b0100 once; cnt_q holds 7 for 10 idle cycles.
//  3 Wrap: start=14, end=1 -> cnt_q 14,15,0,1; done after 4 RUN cycles. start=end=5 -> 1 RUN cycle, then done.
//  4 Round-robin: req=4'b1011 held (re-raised after done) -> grant order 0,1,3,0,1,3; never two gnt bits set.
//  5 Abort: req[1] drops on 2nd RUN cycle -> no done, counter frozen, next grant goes to index 2 or above if pending.
//  6 ena=0 for 4 cycles mid-RUN -> cnt_q and state frozen; resume with the same remaining count; rst_n=0 mid-RUN -> IDLE, gnt=0.

Source files
------------

// File: rtl/counter_load_sequencer.sv
// counter_load_sequencer
// Round-robin sequencer that shares one external loadable up-counter among
// NREQ requesters. A granted requester gets its start value loaded into the
// counter. The counter then runs until it reaches the requester's end value
// and is frozen there, and a one-cycle done pulse is returned to that requester.
// This block is the only driver of the counter's load and c_in pins.
//
// The counter is assumed to be a plain register: c_out <= load ? c_in : c_out + 1.
// Freezing the counter ("HOLD") is therefore done by reloading its own value.

module counter_load_sequencer #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_start,
    input  logic [NREQ*WIDTH-1:0] req_end,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_load,
    output logic [WIDTH-1:0]      cnt_value,
    input  logic [WIDTH-1:0]      cnt_q
);

    // Width of a requester index (round-robin pointer, current owner).
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;       // requester searched first at next arbitration
    logic [PW-1:0]    owner;     // requester that holds the current grant
    logic [WIDTH-1:0] start_q;   // start value captured at grant
    logic [WIDTH-1:0] end_q;     // end value captured at grant

    logic             arb_found;
    logic [PW-1:0]    arb_idx;
    logic [PW-1:0]    ptr_next;
    int               arb_cand;

    logic             owner_req;
    logic             terminal;

    // The owner keeps its request high for the whole job; a low level is an abort.
    assign owner_req = req[owner];

    // The counter has reached the captured end value on this RUN cycle.
    assign terminal = (cnt_q == end_q);

    // Round-robin search: first requester at or after ptr, wrapping modulo NREQ.
    // NOTE: every variable written in this block gets a value before any branch,
    // so no path leaves one unassigned and no latch can be inferred.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_cand = int'(ptr) + i;
            if (arb_cand >= NREQ) begin
                arb_cand = arb_cand - NREQ;
            end
            if (!arb_found && req[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = PW'(arb_cand);
            end
        end
    end

    // Pointer value after a grant: one past the winner, modulo NREQ.
    always_comb begin
        ptr_next = arb_idx + PW'(1);
        if (arb_idx == PW'(NREQ - 1)) begin
            ptr_next = '0;
        end
    end

    // Counter pin drive: HOLD by default, load start in LOAD, release while running.
    always_comb begin
        cnt_load  = 1'b1;
        cnt_value = cnt_q;
        if (!rst_n) begin
            // The counter clears itself during reset; leave its pins quiet.
            cnt_load  = 1'b0;
            cnt_value = '0;
        end else if (ena) begin
            case (state)
                S_LOAD: begin
                    if (owner_req) begin
                        cnt_value = start_q;
                    end
                end
                S_RUN: begin
                    // Aborted or terminal RUN cycles keep the HOLD default.
                    if (owner_req && !terminal) begin
                        cnt_load = 1'b0;
                    end
                end
                default: begin
                    // IDLE holds the counter at whatever value it has.
                end
            endcase
        end
    end

    // Sequencer FSM with registered grant, done and busy outputs.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            ptr     <= '0;
            // NOTE: the captured job registers are cleared too; nothing reads
            // them outside LOAD/RUN, but a known value keeps simulation X-free.
            owner   <= '0;
            start_q <= '0;
            end_q   <= '0;
        end else if (!ena) begin
            // Frozen: everything holds except the done pulse, which must not stretch.
            done <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        gnt     <= NREQ'(1) << arb_idx;
                        owner   <= arb_idx;
                        start_q <= req_start[int'(arb_idx)*WIDTH +: WIDTH];
                        end_q   <= req_end[int'(arb_idx)*WIDTH +: WIDTH];
                        ptr     <= ptr_next;
                        busy    <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!owner_req) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!owner_req) begin
                        // Abort wins over a coincident terminal cycle: no done.
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (terminal) begin
                        done  <= NREQ'(1) << owner;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
